lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Load/store sequencer between the core's memory stage and the data-memory port.
- Accepts one load or store request at a time.
- Checks alignment, generates byte strobes and lane-shifted write data, and runs the memory request/response handshake.
- Extracts and sign/zero-extends load data by funct3 and address low bits, returning one response pulse per request.
- The pipeline stalls while req_ready is low.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waiting for mem_req_ready or mem_rsp_valid before error response; 0 disables timeout.
CNT_W, 8, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core request valid
req_ready  out  1  controller can accept request (high only in IDLE)
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010
req_addr  in  32  byte address
req_wdata  in  32  store data, unshifted (value in low lanes)
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  32  word address: {req_addr[31:2],2'b00}
mem_we  out  1  write enable
mem_wstrb  out  4  byte strobes (0000 for loads)
mem_wdata  out  32  lane-shifted store data
mem_rsp_valid  in  1  read data valid (loads only)
mem_rdata  in  32  read word

Behaviour:
- Reset (async, rst_n=0): state IDLE, timeout counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=00, mem_req_valid=0, mem_addr=0, mem_we=0, mem_wstrb=0, mem_wdata=0.
  - req_ready is combinational from state, so it is 1 in reset.
  - Reset mid-transaction abandons it with no response; memory responses arriving after reset are ignored in IDLE.
- States: IDLE, ISSUE, WAIT_RSP, RESP.
- IDLE: req_ready=1. On req_valid:
  - Latch we, funct3, addr[1:0], wdata.
  - Compute alignment: halfword needs addr[0]=0; word needs addr[1:0]=00.
  - Illegal funct3 (load 011/110/111; store other than 000-010) -> RESP, err=11.
  - Misaligned -> RESP, err=01.
  - Otherwise -> ISSUE.
  - No memory access on error paths.
- ISSUE: mem_req_valid=1; mem_addr, mem_we, mem_wstrb, mem_wdata held stable until mem_req_ready.
  - Strobes: SB 0001<<addr[1:0]; SH 0011<<{addr[1],1'b0}; SW 1111.
  - Write data: wdata<<{addr[1:0],3'b0} for SB; <<{addr[1],4'b0} for SH; unshifted for SW.
  - Handshake (valid&ready): store -> RESP, err=00; load -> WAIT_RSP.
  - Timeout counter increments each cycle in ISSUE/WAIT_RSP and clears on state entry. Counter reaching TIMEOUT_CYCLES -> RESP, err=10, mem_req_valid drops.
- WAIT_RSP: on mem_rsp_valid, capture the extracted value into rsp_rdata -> RESP.
  - Extraction: byte = mem_rdata>>{addr[1:0],3'b0}; half = mem_rdata>>{addr[1],4'b0}.
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
  - Timeout as in ISSUE.
  - mem_rsp_valid outside WAIT_RSP is ignored.
- RESP: rsp_valid=1 for exactly one cycle; rsp_rdata and rsp_err hold until the next RESP. Then -> IDLE.
- Throughput and latency:
  - Minimum load latency with zero-wait memory is 4 cycles from acceptance to rsp_valid: accept, ISSUE, WAIT_RSP (rsp same cycle), RESP.
  - Store minimum is 3 cycles; error paths take 2.
  - A new request is accepted only in IDLE, so there is never more than one request outstanding.
- Response in the same cycle as the request handshake is not supported; the earliest response is the cycle after the handshake.

Test Plan:
1. LB at addr 0x103, mem_rdata=0x80FF_1234, zero-wait memory -> mem_addr=0x100, mem_wstrb=0000; rsp_rdata=0xFFFF_FF80, err=00, rsp_valid exactly 4 cycles after acceptance.
2. LHU at 0x202, mem_rdata=0xBEEF_0001 -> rsp_rdata=0x0000_BEEF. LH at 0x202 -> 0xFFFF_BEEF. LW at 0x204 -> 0xBEEF_0001.
3. SB at 0x301, wdata=0x0000_00AB, mem_req_ready held low 5 cycles -> mem_wstrb=0010, mem_wdata=0x0000_AB00, outputs stable during the stall; rsp_valid 1 cycle after the handshake, err=00.
4. LW at 0x002 and SH at 0x005 -> no mem_req_valid assertion; rsp_err=01, rsp_rdata=0, response 2 cycles after acceptance. Load funct3=011 -> err=11.
5. TIMEOUT_CYCLES=4, load with mem_rsp_valid never asserted -> rsp_err=10 after 4 WAIT_RSP cycles, state returns to IDLE, and the next request is accepted.
6. Assert rst_n=0 in WAIT_RSP -> all outputs 0 immediately and req_ready=1; a late mem_rsp_valid after reset produces no rsp_valid.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the core memory stage and a single data-memory port.
// It handles one request at a time, checks alignment and funct3, runs the memory handshake, and returns one response.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic [1:0]  rsp_err_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_ISSUE    = 2'b01,
    S_WAIT_RSP = 2'b10,
    S_RESP     = 2'b11
  } state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  // A timeout of zero disables the watchdog entirely.
  localparam logic             TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST   =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = ~we;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3[1:0])
      2'b01:   ok = ~off[0];
      2'b10:   ok = (off == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] strb;
    case (f3[1:0])
      2'b00:   strb = 4'b0001 << off;
      2'b01:   strb = 4'b0011 << {off[1], 1'b0};
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] wdata);
    logic [31:0] data;
    case (f3[1:0])
      2'b00:   data = wdata << {off, 3'b000};
      2'b01:   data = wdata << {off[1], 4'b0000};
      default: data = wdata;
    endcase
    return data;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    logic [31:0] data;
    sh_b = rdata >> {off, 3'b000};
    sh_h = rdata >> {off[1], 4'b0000};
    case (f3)
      3'b000:  data = {{24{sh_b[7]}}, sh_b[7:0]};
      3'b001:  data = {{16{sh_h[15]}}, sh_h[15:0]};
      3'b100:  data = {24'h00_0000, sh_b[7:0]};
      3'b101:  data = {16'h0000, sh_h[15:0]};
      default: data = rdata;
    endcase
    return data;
  endfunction

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         funct3_q;
  logic [1:0]         off_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_rdata_q;
  logic [1:0]         rsp_err_q;
  logic               mem_req_valid_q;
  logic [31:0]        mem_addr_q;
  logic               mem_we_q;
  logic [3:0]         mem_wstrb_q;
  logic [31:0]        mem_wdata_q;

  logic               req_legal_s;
  logic               req_aligned_s;
  logic               cnt_expired_s;
  logic [CNT_W-1:0]   cnt_d;

  // Request decode and watchdog expiry.
  always_comb begin
    req_legal_s   = funct3_legal(req_we_i, req_funct3_i);
    req_aligned_s = addr_aligned(req_funct3_i, req_addr_i[1:0]);
    cnt_expired_s = TIMEOUT_EN && (cnt_q == CNT_LAST);
    cnt_d         = cnt_q + CNT_W'(1);
  end

  // Sequencer FSM with registered memory-side and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      funct3_q        <= 3'b000;
      off_q           <= 2'b00;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= 32'h0000_0000;
      rsp_err_q       <= ERR_OK;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= 32'h0000_0000;
      mem_we_q        <= 1'b0;
      mem_wstrb_q     <= 4'b0000;
      mem_wdata_q     <= 32'h0000_0000;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            funct3_q <= req_funct3_i;
            off_q    <= req_addr_i[1:0];
            if (!req_legal_s) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= ERR_ILLEGAL;
              rsp_rdata_q <= 32'h0000_0000;
            end else if (!req_aligned_s) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= ERR_MISALIGN;
              rsp_rdata_q <= 32'h0000_0000;
            end else begin
              state_q         <= S_ISSUE;
              cnt_q           <= '0;
              mem_req_valid_q <= 1'b1;
              mem_addr_q      <= {req_addr_i[31:2], 2'b00};
              mem_we_q        <= req_we_i;
              mem_wstrb_q     <= req_we_i ? store_strb(req_funct3_i, req_addr_i[1:0]) : 4'b0000;
              mem_wdata_q     <= req_we_i ? store_data(req_funct3_i, req_addr_i[1:0], req_wdata_i)
                                          : 32'h0000_0000;
            end
          end
        end
        S_ISSUE: begin
          if (mem_req_ready_i) begin
            mem_req_valid_q <= 1'b0;
            cnt_q           <= '0;
            if (mem_we_q) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= ERR_OK;
              rsp_rdata_q <= 32'h0000_0000;
            end else begin
              state_q <= S_WAIT_RSP;
            end
          end else if (cnt_expired_s) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= S_RESP;
            rsp_valid_q     <= 1'b1;
            rsp_err_q       <= ERR_TIMEOUT;
            rsp_rdata_q     <= 32'h0000_0000;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_WAIT_RSP: begin
          // A response in the same cycle as expiry still counts as a valid load.
          if (mem_rsp_valid_i) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ERR_OK;
            rsp_rdata_q <= load_extract(funct3_q, off_q, mem_rdata_i);
          end else if (cnt_expired_s) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ERR_TIMEOUT;
            rsp_rdata_q <= 32'h0000_0000;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o     = (state_q == S_IDLE);
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_rdata_o     = rsp_rdata_q;
  assign rsp_err_o       = rsp_err_q;
  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_we_o        = mem_we_q;
  assign mem_wstrb_o     = mem_wstrb_q;
  assign mem_wdata_o     = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed vector table, randomized transactions
// against an arithmetic reference model, and hand sequences for timeout and reset.
module tb_lsu_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Index 0: default-timeout DUT, index 1: TIMEOUT_CYCLES=4 DUT.
  logic [1:0]       req_valid_v, req_ready_v, rsp_valid_v;
  logic [1:0]       mem_req_valid_v, mem_req_ready_v, mem_we_v, mem_rsp_valid_v;
  logic [1:0][31:0] rsp_rdata_v, mem_addr_v, mem_wdata_v;
  logic [1:0][1:0]  rsp_err_v;
  logic [1:0][3:0]  mem_wstrb_v;
  logic             req_we;
  logic [2:0]       req_funct3;
  logic [31:0]      req_addr, req_wdata, mem_rdata;

  lsu_mem_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_v[0]), .req_ready_o(req_ready_v[0]),
    .req_we_i(req_we), .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid_v[0]), .rsp_rdata_o(rsp_rdata_v[0]), .rsp_err_o(rsp_err_v[0]),
    .mem_req_valid_o(mem_req_valid_v[0]), .mem_req_ready_i(mem_req_ready_v[0]),
    .mem_addr_o(mem_addr_v[0]), .mem_we_o(mem_we_v[0]), .mem_wstrb_o(mem_wstrb_v[0]),
    .mem_wdata_o(mem_wdata_v[0]), .mem_rsp_valid_i(mem_rsp_valid_v[0]), .mem_rdata_i(mem_rdata)
  );

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) u_dut_to (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_v[1]), .req_ready_o(req_ready_v[1]),
    .req_we_i(req_we), .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid_v[1]), .rsp_rdata_o(rsp_rdata_v[1]), .rsp_err_o(rsp_err_v[1]),
    .mem_req_valid_o(mem_req_valid_v[1]), .mem_req_ready_i(mem_req_ready_v[1]),
    .mem_addr_o(mem_addr_v[1]), .mem_we_o(mem_we_v[1]), .mem_wstrb_o(mem_wstrb_v[1]),
    .mem_wdata_o(mem_wdata_v[1]), .mem_rsp_valid_i(mem_rsp_valid_v[1]), .mem_rdata_i(mem_rdata)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Observed (or expected) outcome of one transaction; cycles counts the acceptance cycle as 1.
  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] maddr;
    logic        we;
    int          cycles;
    int          waits;
    logic        issued;
    logic        stable;
    logic        pulse_ok;
  } obs_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    int          rdy, rsp;
    logic [31:0] e_rdata;
    logic [1:0]  e_err;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata, e_maddr;
    int          e_cycles;
  } vec_t;

  // Drives one request into DUT `sel` and plays the memory with the given wait states.
  task automatic run_txn(input int sel, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                         input int rdy_dly, input int rsp_dly, output obs_t o);
    int   nvalid;
    int   wcnt;
    logic hs;
    logic got;
    o = '{default: '0};
    o.stable = 1'b1;
    o.cycles = -1;
    nvalid = 0; wcnt = 0; hs = 1'b0; got = 1'b0;
    for (int i = 0; i < 50 && !req_ready_v[sel]; i++) @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; mem_rdata = rdata;
    req_valid_v[sel] = 1'b1;
    @(negedge clk);
    req_valid_v[sel] = 1'b0;
    for (int c = 1; c <= 400 && !got; c++) begin
      mem_req_ready_v[sel] = 1'b0;
      mem_rsp_valid_v[sel] = 1'b0;
      if (rsp_valid_v[sel]) begin
        got = 1'b1;
        o.cycles = c + 1;
        o.rdata = rsp_rdata_v[sel];
        o.err = rsp_err_v[sel];
      end else begin
        if (mem_req_valid_v[sel]) begin
          if (!o.issued) begin
            o.issued = 1'b1;
            o.strb = mem_wstrb_v[sel]; o.wdata = mem_wdata_v[sel];
            o.maddr = mem_addr_v[sel]; o.we = mem_we_v[sel];
          end else if (o.strb !== mem_wstrb_v[sel] || o.wdata !== mem_wdata_v[sel] ||
                       o.maddr !== mem_addr_v[sel] || o.we !== mem_we_v[sel]) begin
            o.stable = 1'b0;
          end
          if (nvalid >= rdy_dly) begin
            mem_req_ready_v[sel] = 1'b1;
            hs = 1'b1;
          end
          nvalid++;
        end else if (hs) begin
          o.waits++;
          if (wcnt >= rsp_dly) mem_rsp_valid_v[sel] = 1'b1;
          wcnt++;
        end
        @(negedge clk);
      end
    end
    mem_req_ready_v[sel] = 1'b0;
    mem_rsp_valid_v[sel] = 1'b0;
    @(negedge clk);
    o.pulse_ok = !rsp_valid_v[sel] && req_ready_v[sel];
  endtask

  // Reference: access size in bytes, lane offset and sign extension from plain arithmetic.
  function automatic obs_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int rdy_dly, input int rsp_dly);
    obs_t        e;
    int          size;
    int          off;
    logic        legal;
    logic [31:0] v;
    logic [31:0] mask;
    e = '{default: '0};
    e.stable = 1'b1;
    e.pulse_ok = 1'b1;
    off = int'(addr % 4);
    size = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) begin
      e.err = 2'b11; e.cycles = 2;
    end else if (addr % size != 0) begin
      e.err = 2'b01; e.cycles = 2;
    end else begin
      e.issued = 1'b1;
      e.we = we;
      e.maddr = addr & 32'hFFFF_FFFC;
      if (we) begin
        e.strb = 4'(((1 << size) - 1) << off);
        e.wdata = wdata << (8 * off);
        e.cycles = 3 + rdy_dly;
      end else begin
        v = rdata >> (8 * off);
        if (size < 4) begin
          mask = (32'h1 << (8 * size)) - 32'h1;
          v = v & mask;
          if (!f3[2] && v[8 * size - 1]) v = v | ~mask;
        end
        e.rdata = v;
        e.cycles = 4 + rdy_dly + rsp_dly;
        e.waits = rsp_dly + 1;
      end
    end
    return e;
  endfunction

  task automatic compare(input string tag, input obs_t a, input obs_t e);
    check({tag, ".cycles"}, a.cycles, e.cycles);
    check({tag, ".err"}, 32'(a.err), 32'(e.err));
    check({tag, ".rdata"}, a.rdata, e.rdata);
    check({tag, ".issued"}, 32'(a.issued), 32'(e.issued));
    check({tag, ".pulse"}, 32'(a.pulse_ok), 32'h1);
    if (e.issued) begin
      check({tag, ".maddr"}, a.maddr, e.maddr);
      check({tag, ".we"}, 32'(a.we), 32'(e.we));
      check({tag, ".strb"}, 32'(a.strb), 32'(e.strb));
      check({tag, ".stable"}, 32'(a.stable), 32'h1);
      if (e.we) check({tag, ".wdata"}, a.wdata, e.wdata);
      else      check({tag, ".waits"}, a.waits, e.waits);
    end
  endtask

  vec_t vecs[12];
  obs_t obs;
  obs_t exp_o;

  initial begin
    vecs[0]  = '{1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 0, 32'hFFFF_FF80, 2'b00, 4'b0000, 32'h0, 32'h100, 4};
    vecs[1]  = '{1'b0, 3'b101, 32'h202, 32'h0, 32'hBEEF_0001, 0, 0, 32'h0000_BEEF, 2'b00, 4'b0000, 32'h0, 32'h200, 4};
    vecs[2]  = '{1'b0, 3'b001, 32'h202, 32'h0, 32'hBEEF_0001, 0, 0, 32'hFFFF_BEEF, 2'b00, 4'b0000, 32'h0, 32'h200, 4};
    vecs[3]  = '{1'b0, 3'b010, 32'h204, 32'h0, 32'hBEEF_0001, 0, 0, 32'hBEEF_0001, 2'b00, 4'b0000, 32'h0, 32'h204, 4};
    vecs[4]  = '{1'b1, 3'b000, 32'h301, 32'h0000_00AB, 32'h0, 5, 0, 32'h0, 2'b00, 4'b0010, 32'h0000_AB00, 32'h300, 8};
    vecs[5]  = '{1'b0, 3'b010, 32'h002, 32'h0, 32'h0, 0, 0, 32'h0, 2'b01, 4'b0000, 32'h0, 32'h0, 2};
    vecs[6]  = '{1'b1, 3'b001, 32'h005, 32'h1234, 32'h0, 0, 0, 32'h0, 2'b01, 4'b0000, 32'h0, 32'h0, 2};
    vecs[7]  = '{1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 32'h0, 2'b11, 4'b0000, 32'h0, 32'h0, 2};
    vecs[8]  = '{1'b0, 3'b100, 32'h101, 32'h0, 32'h1234_80FF, 1, 2, 32'h0000_0080, 2'b00, 4'b0000, 32'h0, 32'h100, 7};
    vecs[9]  = '{1'b1, 3'b001, 32'h206, 32'h1234_CAFE, 32'h0, 0, 0, 32'h0, 2'b00, 4'b1100, 32'hCAFE_0000, 32'h204, 3};
    vecs[10] = '{1'b1, 3'b010, 32'h040, 32'hDEAD_BEEF, 32'h0, 2, 0, 32'h0, 2'b00, 4'b1111, 32'hDEAD_BEEF, 32'h040, 5};
    vecs[11] = '{1'b1, 3'b100, 32'h040, 32'h0, 32'h0, 0, 0, 32'h0, 2'b11, 4'b0000, 32'h0, 32'h0, 2};

    rst_n = 1'b0;
    req_valid_v = 2'b00; mem_req_ready_v = 2'b00; mem_rsp_valid_v = 2'b00;
    req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0; mem_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("reset.req_ready", 32'(req_ready_v[0]), 32'h1);
    check("reset.rsp_valid", 32'(rsp_valid_v[0]), 32'h0);
    check("reset.mem_req_valid", 32'(mem_req_valid_v[0]), 32'h0);
    check("reset.mem_addr", mem_addr_v[0], 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_txn(0, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
              vecs[i].rdy, vecs[i].rsp, obs);
      exp_o = '{default: '0};
      exp_o.rdata = vecs[i].e_rdata; exp_o.err = vecs[i].e_err; exp_o.strb = vecs[i].e_strb;
      exp_o.wdata = vecs[i].e_wdata; exp_o.maddr = vecs[i].e_maddr; exp_o.we = vecs[i].we;
      exp_o.cycles = vecs[i].e_cycles; exp_o.issued = (vecs[i].e_err == 2'b00);
      exp_o.waits = vecs[i].rsp + 1;
      compare($sformatf("vec%0d", i), obs, exp_o);
    end

    for (int i = 0; i < 60; i++) begin
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_addr, r_wdata, r_rdata;
      int          r_rdy, r_rsp;
      r_we = 1'($urandom_range(0, 1));
      r_f3 = 3'($urandom_range(0, 7));
      r_addr = $urandom; r_wdata = $urandom; r_rdata = $urandom;
      r_rdy = int'($urandom_range(0, 3));
      r_rsp = int'($urandom_range(0, 3));
      run_txn(0, r_we, r_f3, r_addr, r_wdata, r_rdata, r_rdy, r_rsp, obs);
      compare($sformatf("rnd%0d", i), obs, model(r_we, r_f3, r_addr, r_wdata, r_rdata, r_rdy, r_rsp));
    end

    // Short-timeout DUT: load with no read response, then a normal store.
    run_txn(1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h5555_AAAA, 0, 1000, obs);
    check("to_rsp.err", 32'(obs.err), 32'h2);
    check("to_rsp.rdata", obs.rdata, 32'h0);
    check("to_rsp.waits", obs.waits, 4);
    check("to_rsp.cycles", obs.cycles, 7);
    check("to_rsp.idle", 32'(obs.pulse_ok), 32'h1);
    run_txn(1, 1'b1, 3'b010, 32'h20, 32'h1357_9BDF, 32'h0, 0, 0, obs);
    compare("to_next", obs, model(1'b1, 3'b010, 32'h20, 32'h1357_9BDF, 32'h0, 0, 0));
    run_txn(1, 1'b1, 3'b010, 32'h24, 32'h1111_2222, 32'h0, 1000, 0, obs);
    check("to_issue.err", 32'(obs.err), 32'h2);
    check("to_issue.cycles", obs.cycles, 6);
    check("to_issue.issued", 32'(obs.issued), 32'h1);
    run_txn(1, 1'b0, 3'b100, 32'h31, 32'h0, 32'h0000_7F00, 0, 0, obs);
    compare("to_after", obs, model(1'b0, 3'b100, 32'h31, 32'h0, 32'h0000_7F00, 0, 0));

    // Reset while waiting for read data, then a stray late response.
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300; mem_rdata = 32'hFFFF_FFFF;
    req_valid_v[0] = 1'b1;
    @(negedge clk);
    req_valid_v[0] = 1'b0;
    check("rst6.issue", 32'(mem_req_valid_v[0]), 32'h1);
    mem_req_ready_v[0] = 1'b1;
    @(negedge clk);
    mem_req_ready_v[0] = 1'b0;
    check("rst6.wait", 32'({mem_req_valid_v[0], req_ready_v[0], rsp_valid_v[0]}), 32'h0);
    rst_n = 1'b0;
    #1;
    check("rst6.req_ready", 32'(req_ready_v[0]), 32'h1);
    check("rst6.mem_addr", mem_addr_v[0], 32'h0);
    check("rst6.ctrl", 32'({rsp_valid_v[0], mem_req_valid_v[0], mem_we_v[0], mem_wstrb_v[0], rsp_err_v[0]}), 32'h0);
    check("rst6.data", rsp_rdata_v[0] | mem_wdata_v[0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rsp_valid_v[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst6.late%0d", i), 32'(rsp_valid_v[0]), 32'h0);
    end
    mem_rsp_valid_v[0] = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
